sprom_rdata_checker: RTL and testbench

- Passive read-data checker placed directly downstream of the single-port ROM under test. It consumes the stimulus generator's control outputs and the ROM's read data.
- Keeps a cycle-accurate reference model of the ROM read path: address register, RAM latch, optional output register and reset.
- Compares the ROM read data against the model every cycle once the model holds valid data.
- Counts checks and mismatches, captures the first failure, and reports pass/fail after the generator's sim_end.

---
 rtl/sprom_rdata_checker.sv | 173 +++++++++++++++++
 tb/tb_sprom_rdata_checker.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sprom_rdata_checker.sv
// Passive read-data checker for a single-port ROM: models the ROM read path
// cycle-accurately, compares every valid cycle and reports pass/fail at the end.
module sprom_rdata_checker #(
    parameter int                      DATA_WIDTH_A    = 16,
    parameter int                      ADDR_WIDTH_A    = 4,
    parameter logic                    OUTPUT_REG      = 1'b1,
    parameter logic                    RE_POLARITY     = 1'b1,
    parameter logic                    ADDREN_POLARITY = 1'b1,
    parameter logic                    RST_POLARITY    = 1'b1,
    parameter logic [DATA_WIDTH_A-1:0] INIT_MULT       = 16'h0101,
    parameter logic [DATA_WIDTH_A-1:0] INIT_OFFSET     = 16'h0000,
    parameter int                      DRAIN_CYCLES    = 3
) (
    input  logic                    clk_i,
    input  logic                    rstn,
    input  logic                    bram_rst,
    input  logic                    re,
    input  logic                    addren,
    input  logic [ADDR_WIDTH_A-1:0] addr,
    input  logic [DATA_WIDTH_A-1:0] rdata_a,
    input  logic                    sim_end,
    output logic [31:0]             chk_cnt,
    output logic [15:0]             err_cnt,
    output logic                    err_flag,
    output logic [ADDR_WIDTH_A-1:0] first_err_addr,
    output logic [DATA_WIDTH_A-1:0] first_err_exp,
    output logic [DATA_WIDTH_A-1:0] first_err_got,
    output logic                    done,
    output logic                    pass
);

    localparam int          PROD_W     = DATA_WIDTH_A + ADDR_WIDTH_A;
    localparam logic [31:0] DRAIN_LAST = (DRAIN_CYCLES > 0) ? 32'(DRAIN_CYCLES - 1) : 32'd0;
    localparam logic        DRAIN_NONE = (DRAIN_CYCLES == 0) ? 1'b1 : 1'b0;

    // ROM init pattern; the product is kept wide and then truncated
    function automatic logic [DATA_WIDTH_A-1:0] rom_f(input logic [ADDR_WIDTH_A-1:0] a);
        logic [PROD_W-1:0] prod;
        prod = PROD_W'(a) * PROD_W'(INIT_MULT);
        return prod[DATA_WIDTH_A-1:0] + INIT_OFFSET;
    endfunction

    logic                    re_a_s;
    logic                    ae_a_s;
    logic                    rst_a_s;
    logic [ADDR_WIDTH_A-1:0] addr_sel_s;
    logic [DATA_WIDTH_A-1:0] exp_s;
    logic                    model_valid_s;
    logic                    check_s;
    logic                    mism_s;
    logic                    end_now_s;

    logic [ADDR_WIDTH_A-1:0] a_reg_r;
    logic [DATA_WIDTH_A-1:0] d1_r;
    logic [DATA_WIDTH_A-1:0] d2_r;
    logic                    v1_r;
    logic                    v2_r;
    logic                    seen_end_r;
    logic [31:0]             drain_cnt_r;

    logic [ADDR_WIDTH_A-1:0] a_reg_nxt_s;
    logic [DATA_WIDTH_A-1:0] d1_nxt_s;
    logic [DATA_WIDTH_A-1:0] d2_nxt_s;
    logic [31:0]             chk_nxt_s;
    logic [15:0]             err_nxt_s;
    logic                    pass_nxt_s;

    assign re_a_s        = (re == RE_POLARITY);
    assign ae_a_s        = (addren == ADDREN_POLARITY);
    assign rst_a_s       = (bram_rst == RST_POLARITY);
    assign addr_sel_s    = ae_a_s ? addr : a_reg_r;
    assign exp_s         = OUTPUT_REG ? d2_r : d1_r;
    assign model_valid_s = OUTPUT_REG ? v2_r : v1_r;
    assign check_s       = model_valid_s && !done;
    // Case inequality so that X/Z read data is reported as a mismatch
    assign mism_s        = check_s && (rdata_a !== exp_s);

    // Next state of the ROM read-path model (address register, latch, output register)
    always_comb begin
        a_reg_nxt_s = a_reg_r;
        d1_nxt_s    = d1_r;
        if (rst_a_s) begin
            d1_nxt_s = {DATA_WIDTH_A{1'b0}};
        end else if (re_a_s) begin
            a_reg_nxt_s = addr_sel_s;
            d1_nxt_s    = rom_f(addr_sel_s);
        end else begin
            a_reg_nxt_s = a_reg_r;
            d1_nxt_s    = d1_r;
        end
        d2_nxt_s = rst_a_s ? {DATA_WIDTH_A{1'b0}} : d1_r;
    end

    // Saturating counters, end-of-run detection and pass verdict
    always_comb begin
        chk_nxt_s  = chk_cnt;
        err_nxt_s  = err_cnt;
        pass_nxt_s = pass;
        end_now_s  = 1'b0;
        if (check_s && (chk_cnt != 32'hFFFF_FFFF)) begin
            chk_nxt_s = chk_cnt + 32'd1;
        end else begin
            chk_nxt_s = chk_cnt;
        end
        if (mism_s && (err_cnt != 16'hFFFF)) begin
            err_nxt_s = err_cnt + 16'd1;
        end else begin
            err_nxt_s = err_cnt;
        end
        if (done) begin
            end_now_s = 1'b0;
        end else if (DRAIN_NONE) begin
            end_now_s = sim_end || seen_end_r;
        end else begin
            end_now_s = seen_end_r && (drain_cnt_r == DRAIN_LAST);
        end
        // A run with zero compared cycles is a failure
        if (end_now_s) begin
            pass_nxt_s = (err_nxt_s == 16'd0) && (chk_nxt_s != 32'd0);
        end else begin
            pass_nxt_s = pass;
        end
    end

    // Model registers; valid flags are sticky until rstn
    always_ff @(posedge clk_i) begin
        if (!rstn) begin
            a_reg_r <= {ADDR_WIDTH_A{1'b0}};
            d1_r    <= {DATA_WIDTH_A{1'b0}};
            d2_r    <= {DATA_WIDTH_A{1'b0}};
            v1_r    <= 1'b0;
            v2_r    <= 1'b0;
        end else begin
            a_reg_r <= a_reg_nxt_s;
            d1_r    <= d1_nxt_s;
            d2_r    <= d2_nxt_s;
            v1_r    <= v1_r | re_a_s | rst_a_s;
            v2_r    <= v2_r | v1_r;
        end
    end

    // Result registers; the first_err_* fields load only on the first mismatch
    always_ff @(posedge clk_i) begin
        if (!rstn) begin
            chk_cnt        <= 32'd0;
            err_cnt        <= 16'd0;
            err_flag       <= 1'b0;
            first_err_addr <= {ADDR_WIDTH_A{1'b0}};
            first_err_exp  <= {DATA_WIDTH_A{1'b0}};
            first_err_got  <= {DATA_WIDTH_A{1'b0}};
            seen_end_r     <= 1'b0;
            drain_cnt_r    <= 32'd0;
            done           <= 1'b0;
            pass           <= 1'b0;
        end else begin
            chk_cnt <= chk_nxt_s;
            err_cnt <= err_nxt_s;
            if (mism_s && !err_flag) begin
                err_flag       <= 1'b1;
                first_err_addr <= a_reg_r;
                first_err_exp  <= exp_s;
                first_err_got  <= rdata_a;
            end
            seen_end_r <= seen_end_r | (sim_end & ~done);
            if (seen_end_r && !done) begin
                drain_cnt_r <= drain_cnt_r + 32'd1;
            end
            done <= done | end_now_s;
            pass <= pass_nxt_s;
        end
    end

endmodule

// File: tb/tb_sprom_rdata_checker.sv
// Randomized self-checking bench for sprom_rdata_checker; the bench also plays
// the ROM, driving either its own reference read data or deliberately wrong data.
module tb_sprom_rdata_checker;

    localparam int   DW    = 16;
    localparam int   AW    = 4;
    localparam bit   OREG  = 1'b1;
    localparam int   LAT   = OREG ? 2 : 1;
    localparam int   DRAIN = 3;
    localparam int   MULT  = 32'h0101;
    localparam int   OFF   = 32'h0000;

    logic          clk_i;
    logic          rstn;
    logic          bram_rst;
    logic          re;
    logic          addren;
    logic [AW-1:0] addr;
    logic [DW-1:0] rdata_a;
    logic          sim_end;
    logic [31:0]   chk_cnt;
    logic [15:0]   err_cnt;
    logic          err_flag;
    logic [AW-1:0] first_err_addr;
    logic [DW-1:0] first_err_exp;
    logic [DW-1:0] first_err_got;
    logic          done;
    logic          pass;

    int n_tests;
    int n_fail;

    sprom_rdata_checker #(
        .DATA_WIDTH_A(DW), .ADDR_WIDTH_A(AW), .OUTPUT_REG(OREG),
        .RE_POLARITY(1'b1), .ADDREN_POLARITY(1'b1), .RST_POLARITY(1'b1),
        .INIT_MULT(16'h0101), .INIT_OFFSET(16'h0000), .DRAIN_CYCLES(DRAIN)
    ) dut (
        .clk_i(clk_i), .rstn(rstn), .bram_rst(bram_rst), .re(re), .addren(addren),
        .addr(addr), .rdata_a(rdata_a), .sim_end(sim_end),
        .chk_cnt(chk_cnt), .err_cnt(err_cnt), .err_flag(err_flag),
        .first_err_addr(first_err_addr), .first_err_exp(first_err_exp),
        .first_err_got(first_err_got), .done(done), .pass(pass)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Reference model: a history of what the ROM latch held after each edge,
    // delayed by the read latency, plus a scoreboard of the expected results.
    int            n_edge;
    int            first_trig;
    int            end_edge;
    logic [DW-1:0] hist[$];
    bit            rsth[$];
    logic [AW-1:0] m_areg;
    logic [31:0]   m_chk;
    logic [15:0]   m_err;
    bit            m_flag;
    logic [AW-1:0] m_faddr;
    logic [DW-1:0] m_fexp;
    logic [DW-1:0] m_fgot;
    bit            m_done;
    bit            m_pass;
    bit            m_seen;

    function automatic logic [DW-1:0] rom_val(input int a);
        return 16'((a * MULT + OFF) % 65536);
    endfunction

    function automatic logic [DW-1:0] cur_exp();
        if (LAT == 1) return (hist.size() > 0) ? hist[hist.size()-1] : 16'h0000;
        if (rsth.size() > 0 && rsth[rsth.size()-1]) return 16'h0000;
        return (hist.size() > 1) ? hist[hist.size()-2] : 16'h0000;
    endfunction

    function automatic bit cur_valid();
        return (first_trig >= 0) && (n_edge >= first_trig + LAT);
    endfunction

    task automatic model_reset();
        n_edge = 0; first_trig = -1; end_edge = 0;
        hist.delete(); rsth.delete();
        m_areg = 4'h0; m_chk = 32'd0; m_err = 16'd0; m_flag = 1'b0;
        m_faddr = 4'h0; m_fexp = 16'h0000; m_fgot = 16'h0000;
        m_done = 1'b0; m_pass = 1'b0; m_seen = 1'b0;
    endtask

    // One clock: drive inputs, advance the model, wait for the edge, settle.
    // lit=1 drives v as read data; lit=0 drives the model's data XOR v.
    task automatic step(input bit rn, input bit rs, input bit rv, input bit av,
                        input logic [AW-1:0] a, input bit se, input bit lit,
                        input logic [DW-1:0] v);
        logic [DW-1:0] e;
        logic [DW-1:0] rd;
        e  = cur_exp();
        rd = lit ? v : (e ^ v);
        rstn = rn; bram_rst = rs; re = rv; addren = av; addr = a; sim_end = se; rdata_a = rd;
        if (!rn) begin
            model_reset();
        end else begin
            if (cur_valid() && !m_done) begin
                if (m_chk != 32'hFFFF_FFFF) m_chk = m_chk + 32'd1;
                if (rd !== e) begin
                    if (m_err != 16'hFFFF) m_err = m_err + 16'd1;
                    if (!m_flag) begin
                        m_flag = 1'b1; m_faddr = m_areg; m_fexp = e; m_fgot = rd;
                    end
                end
            end
            if (!m_done) begin
                if (!m_seen && se) begin m_seen = 1'b1; end_edge = n_edge; end
                if (m_seen && n_edge == end_edge + DRAIN) begin
                    m_done = 1'b1;
                    m_pass = (m_err == 16'd0) && (m_chk != 32'd0);
                end
            end
            if ((rs || rv) && first_trig < 0) first_trig = n_edge;
            rsth.push_back(rs);
            if (rs) begin
                hist.push_back(16'h0000);
            end else if (rv) begin
                if (av) m_areg = a;
                hist.push_back(rom_val(int'(m_areg)));
            end else begin
                hist.push_back((hist.size() > 0) ? hist[hist.size()-1] : 16'h0000);
            end
            n_edge++;
        end
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        step(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 16'h0000);
        step(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 16'h0000);
    endtask

    task automatic test_reset();
        do_reset();
        n_tests++; if (chk_cnt !== 32'd0) begin n_fail++; $display("FAIL reset_chk: got %0d want 0", chk_cnt); end
        n_tests++; if (err_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_err: got %0d want 0", err_cnt); end
        n_tests++; if ({err_flag, done, pass} !== 3'b000) begin n_fail++; $display("FAIL reset_flags: got %b want 000", {err_flag, done, pass}); end
        n_tests++; if ({first_err_addr, first_err_exp, first_err_got} !== 36'd0) begin
            n_fail++; $display("FAIL reset_first: got %h %h %h want 0", first_err_addr, first_err_exp, first_err_got); end
    endtask

    // Addresses 0..15 read back to back; expected data written out directly
    task automatic test_seq_read();
        logic [DW-1:0] v;
        logic [15:0]   kk;
        do_reset();
        for (int k = 0; k < 21; k++) begin
            kk = 16'(k);
            if (k < 2) v = 16'h0000;
            else if (k <= 17) v = 16'h0101 * (kk - 16'd2);
            else v = 16'h0F0F;
            step(1'b1, 1'b0, (k < 16), 1'b1, 4'(k), (k >= 17), 1'b1, v);
            n_tests++; if (err_cnt !== 16'd0) begin n_fail++; $display("FAIL seq_err@%0d: got %0d want 0", k, err_cnt); end
        end
        n_tests++; if (chk_cnt !== 32'd19) begin n_fail++; $display("FAIL seq_chk: got %0d want 19", chk_cnt); end
        n_tests++; if (chk_cnt !== m_chk) begin n_fail++; $display("FAIL seq_chk_model: got %0d want %0d", chk_cnt, m_chk); end
        n_tests++; if ({done, pass} !== 2'b11) begin n_fail++; $display("FAIL seq_done_pass: got %b want 11", {done, pass}); end
    endtask

    task automatic test_addren_hold();
        do_reset();
        step(1'b1, 1'b0, 1'b1, 1'b1, 4'h5, 1'b0, 1'b1, 16'h0606);
        for (int k = 0; k < 7; k++)
            step(1'b1, 1'b0, 1'b1, 1'b0, 4'($urandom_range(0, 15)), 1'b0, 1'b1, 16'h0606);
        n_tests++; if (err_flag !== 1'b1) begin n_fail++; $display("FAIL ae_flag: got %b want 1", err_flag); end
        n_tests++; if (first_err_addr !== 4'h5) begin n_fail++; $display("FAIL ae_addr: got %h want 5", first_err_addr); end
        n_tests++; if (first_err_exp !== 16'h0505) begin n_fail++; $display("FAIL ae_exp: got %h want 0505", first_err_exp); end
        n_tests++; if (first_err_got !== 16'h0606) begin n_fail++; $display("FAIL ae_got: got %h want 0606", first_err_got); end
        n_tests++; if (err_cnt !== 16'd6) begin n_fail++; $display("FAIL ae_err: got %0d want 6", err_cnt); end
    endtask

    task automatic test_re_hold();
        do_reset();
        step(1'b1, 1'b0, 1'b1, 1'b1, 4'h9, 1'b0, 1'b1, 16'h0909);
        for (int k = 0; k < 8; k++)
            step(1'b1, 1'b0, 1'b0, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 1'b0, 1'b1, 16'h0909);
        n_tests++; if (err_cnt !== 16'd0) begin n_fail++; $display("FAIL re_err: got %0d want 0", err_cnt); end
        n_tests++; if (chk_cnt !== 32'd7) begin n_fail++; $display("FAIL re_chk: got %0d want 7", chk_cnt); end
    endtask

    // bram_rst with re at addr 7: output clears and the address register keeps 3
    task automatic test_bram_rst();
        do_reset();
        step(1'b1, 1'b0, 1'b1, 1'b1, 4'h3, 1'b0, 1'b1, 16'h0000);
        step(1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 16'h0000);
        step(1'b1, 1'b1, 1'b1, 1'b1, 4'h7, 1'b0, 1'b1, 16'h0303);
        for (int k = 0; k < 3; k++) step(1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 16'h0000);
        step(1'b1, 1'b0, 1'b1, 1'b0, 4'h7, 1'b0, 1'b1, 16'h0000);
        step(1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 16'h0000);
        step(1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 16'h0303);
        step(1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 16'h0303);
        n_tests++; if (err_cnt !== 16'd0) begin n_fail++; $display("FAIL rst_err: got %0d want 0", err_cnt); end
        n_tests++; if (chk_cnt !== 32'd8) begin n_fail++; $display("FAIL rst_chk: got %0d want 8", chk_cnt); end
    endtask

    task automatic test_corruptions();
        logic [31:0] frozen;
        logic [DW-1:0] xm;
        do_reset();
        for (int k = 0; k < 30; k++) begin
            xm = (k == 8 || k == 14 || k == 21) ? 16'($urandom_range(1, 65535)) : 16'h0000;
            step(1'b1, ($urandom_range(0, 7) == 0), (k == 0) || ($urandom_range(0, 1) == 1),
                 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 1'b0, 1'b0, xm);
        end
        for (int k = 0; k < 4; k++) step(1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 16'h0000);
        n_tests++; if (err_cnt !== 16'd3) begin n_fail++; $display("FAIL cor_err: got %0d want 3", err_cnt); end
        n_tests++; if ({done, pass} !== 2'b10) begin n_fail++; $display("FAIL cor_done_pass: got %b want 10", {done, pass}); end
        n_tests++; if (first_err_addr !== m_faddr) begin n_fail++; $display("FAIL cor_addr: got %h want %h", first_err_addr, m_faddr); end
        n_tests++; if (first_err_exp !== m_fexp) begin n_fail++; $display("FAIL cor_exp: got %h want %h", first_err_exp, m_fexp); end
        n_tests++; if (first_err_got !== m_fgot) begin n_fail++; $display("FAIL cor_got: got %h want %h", first_err_got, m_fgot); end
        n_tests++; if (chk_cnt !== m_chk) begin n_fail++; $display("FAIL cor_chk: got %0d want %0d", chk_cnt, m_chk); end
        frozen = m_chk;
        for (int k = 0; k < 5; k++) step(1'b1, 1'b0, 1'b1, 1'b1, 4'(k), 1'b1, 1'b0, 16'hFFFF);
        n_tests++; if (chk_cnt !== frozen) begin n_fail++; $display("FAIL cor_frozen_chk: got %0d want %0d", chk_cnt, frozen); end
        n_tests++; if (err_cnt !== 16'd3) begin n_fail++; $display("FAIL cor_frozen_err: got %0d want 3", err_cnt); end
    endtask

    task automatic test_mid_reset();
        do_reset();
        step(1'b1, 1'b0, 1'b1, 1'b1, 4'h2, 1'b0, 1'b0, 16'h0000);
        step(1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 16'h0000);
        step(1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 16'h0010);
        n_tests++; if (err_cnt !== 16'd1) begin n_fail++; $display("FAIL mid_err_before: got %0d want 1", err_cnt); end
        step(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 16'h0000);
        n_tests++; if ({chk_cnt, err_cnt, err_flag, done, pass} !== 51'd0) begin
            n_fail++; $display("FAIL mid_reset_outs: got %0d %0d %b%b%b want 0", chk_cnt, err_cnt, err_flag, done, pass); end
        n_tests++; if ({first_err_addr, first_err_exp, first_err_got} !== 36'd0) begin
            n_fail++; $display("FAIL mid_reset_first: got %h %h %h want 0", first_err_addr, first_err_exp, first_err_got); end
        for (int k = 0; k < 5; k++) step(1'b1, 1'b0, 1'b0, 1'b1, 4'(k), 1'b0, 1'b1, 16'($urandom_range(0, 65535)));
        for (int k = 0; k < 4; k++) step(1'b1, 1'b0, 1'b0, 1'b1, 4'(k), 1'b1, 1'b1, 16'($urandom_range(0, 65535)));
        n_tests++; if (chk_cnt !== 32'd0) begin n_fail++; $display("FAIL mid_chk: got %0d want 0", chk_cnt); end
        n_tests++; if (err_cnt !== 16'd0) begin n_fail++; $display("FAIL mid_err: got %0d want 0", err_cnt); end
        n_tests++; if ({done, pass} !== 2'b10) begin n_fail++; $display("FAIL mid_done_pass: got %b want 10", {done, pass}); end
    endtask

    task automatic test_random_long();
        logic [DW-1:0] xm;
        do_reset();
        for (int k = 0; k < 300; k++) begin
            xm = ($urandom_range(0, 19) == 0) ? 16'($urandom_range(1, 65535)) : 16'h0000;
            step(($urandom_range(0, 99) != 0), ($urandom_range(0, 9) == 0), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), (k >= 250), 1'b0, xm);
            n_tests++; if (chk_cnt !== m_chk) begin n_fail++; $display("FAIL rnd_chk@%0d: got %0d want %0d", k, chk_cnt, m_chk); end
            n_tests++; if (err_cnt !== m_err) begin n_fail++; $display("FAIL rnd_err@%0d: got %0d want %0d", k, err_cnt, m_err); end
            n_tests++; if ({err_flag, done, pass} !== {m_flag, m_done, m_pass}) begin
                n_fail++; $display("FAIL rnd_flags@%0d: got %b%b%b want %b%b%b", k, err_flag, done, pass, m_flag, m_done, m_pass); end
        end
        n_tests++; if ({first_err_addr, first_err_exp, first_err_got} !== {m_faddr, m_fexp, m_fgot}) begin
            n_fail++; $display("FAIL rnd_first: got %h %h %h want %h %h %h",
                               first_err_addr, first_err_exp, first_err_got, m_faddr, m_fexp, m_fgot); end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        model_reset();
        test_reset();
        test_seq_read();
        test_addren_hold();
        test_re_hold();
        test_bram_rst();
        test_corruptions();
        test_mid_reset();
        test_random_long();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
